// File: rtl/uart_tx_arbiter.sv
// Shares one async_transmitter between NREQ byte sources. By default it uses round-robin grants.
// Build option TXARB_FIXED_PRIO_EN: fixed priority, where the lowest requesting index always wins.
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int GW            = 2,
  parameter int BUSY_WAIT_MAX = 16
) (
  input  logic              clk50m,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [GW-1:0]     grant_id,
  output logic              arb_busy,
  output logic              err_timeout,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic [2:0]        dbg_state
);

  // Handshake: a requester holds req (and its byte) until it sees its ack bit for one cycle;
  // the transmitter is started by a one-cycle tx_start and owns the line while tx_busy is high.
  localparam int CW = (BUSY_WAIT_MAX > 2) ? $clog2(BUSY_WAIT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ACK       = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [7:0]      data_q, data_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            start_q, start_d;
  logic            tout_q, tout_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

  logic            win_found;
  logic [GW-1:0]   win_id;

`ifdef TXARB_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[GW'(i)]) begin
        win_found = 1'b1;
        win_id    = GW'(i);
      end
    end
  end
`else
  logic [GW-1:0] last_grant_q, last_grant_d;

  // Scan starts one past the last winner so every held request is reached within NREQ grants.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_g;
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    idx_g     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(last_grant_q) + 1 + i;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_g = GW'(idx);
      if (!win_found && req[idx_g]) begin
        win_found = 1'b1;
        win_id    = idx_g;
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    data_d     = data_q;
    wait_cnt_d = wait_cnt_q;
    ack_d      = '0;
    start_d    = 1'b0;
    tout_d     = 1'b0;
`ifndef TXARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found && !tx_busy) begin
          state_d = S_START;
          grant_d = win_id;
          data_d  = req_data[{win_id, 3'b000} +: 8];
          start_d = 1'b1;
        end
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
          // Counter stops at the limit: leaving for ACK means it never wraps.
          if (wait_cnt_d == CW'(BUSY_WAIT_MAX - 1)) begin
            state_d = S_ACK;
            ack_d   = NREQ'(1) << grant_q;
            tout_d  = 1'b1;
          end
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = S_ACK;
          ack_d   = NREQ'(1) << grant_q;
        end
      end
      S_ACK: begin
`ifndef TXARB_FIXED_PRIO_EN
        last_grant_d = grant_q;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk50m or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      data_q     <= '0;
      ack_q      <= '0;
      start_q    <= 1'b0;
      tout_q     <= 1'b0;
      busy_q     <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      start_q    <= start_d;
      tout_q     <= tout_d;
      busy_q     <= busy_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifndef TXARB_FIXED_PRIO_EN
  // Reset hands the first turn to requester 0.
  always_ff @(posedge clk50m or negedge reset) begin
    if (!reset) last_grant_q <= GW'(NREQ - 1);
    else        last_grant_q <= last_grant_d;
  end
`endif

  assign ack         = ack_q;
  assign grant_id    = grant_q;
  assign arb_busy    = busy_q;
  assign err_timeout = tout_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign dbg_state   = state_q;

endmodule
